// File: rtl/mac_pkg.sv
// Shared types, default widths and the saturating add used by the MAC accumulator.
package mac_pkg;

  localparam int unsigned ADefW   = 8;
  localparam int unsigned BDefW   = 8;
  localparam int unsigned AccDefW = 24;
  // Datapath is computed at this fixed width and trimmed to ACC_W by the caller.
  localparam int unsigned MaxAccW = 64;

  typedef logic [MaxAccW-1:0] acc_wide_t;
  typedef logic [MaxAccW:0]   sat_res_t;  // {ovf, result}

  typedef struct packed {
    logic      v;
    logic      sgn;
    acc_wide_t prod;  // zero-padded above A_W+B_W
  } s2_stage_t;

  // acc and ext_prod must already be extended to MaxAccW per sgn. Range is checked against acc_w.
  function automatic sat_res_t sat_add(input acc_wide_t   acc,
                                       input acc_wide_t   ext_prod,
                                       input logic        sgn,
                                       input logic        saturate,
                                       input int unsigned acc_w);
    sat_res_t  s;
    sat_res_t  one;
    sat_res_t  smax;
    sat_res_t  smin;
    sat_res_t  umax;
    acc_wide_t res;
    logic      hi;
    logic      lo;
    one  = sat_res_t'(1);
    s    = {sgn & acc[MaxAccW-1], acc} + {sgn & ext_prod[MaxAccW-1], ext_prod};
    smax = (one << (acc_w - 1)) - one;
    smin = ~smax;
    umax = (one << acc_w) - one;
    if (sgn) begin
      hi = $signed(s) > $signed(smax);
      lo = $signed(s) < $signed(smin);
    end else begin
      hi = s > umax;
      lo = 1'b0;
    end
    res = s[MaxAccW-1:0];
    if (saturate && hi) begin
      res = sgn ? smax[MaxAccW-1:0] : umax[MaxAccW-1:0];
    end else if (saturate && lo) begin
      res = smin[MaxAccW-1:0];
    end
    return {hi | lo, res};
  endfunction

endpackage

// File: rtl/mac_pipe_sat_if.sv
// Operand and result signals of the pipelined MAC; master drives operands, slave is the MAC.
interface mac_pipe_sat_if #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = 24
) ();

  logic             en;
  logic             clr;
  logic             sgn;
  logic [A_W-1:0]   a_in;
  logic [B_W-1:0]   b_in;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             ovf;
  logic             busy;

  modport master (
    output en, clr, sgn, a_in, b_in,
    input  acc_out, acc_valid, ovf, busy
  );

  modport slave (
    input  en, clr, sgn, a_in, b_in,
    output acc_out, acc_valid, ovf, busy
  );

endinterface

// File: rtl/mac_sat_acc.sv
// S3 of the MAC: accumulator register with per-sample signedness, saturation/wrap and sticky ovf.
module mac_sat_acc
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned PROD_W   = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             in_v_i,
  input  logic             in_sgn_i,
  input  acc_wide_t        in_prod_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_valid_q, acc_valid_d;
  logic             ovf_q, ovf_d;
  acc_wide_t        acc_ext;
  acc_wide_t        prod_ext;
  acc_wide_t        prod_hi_mask;
  sat_res_t         sat;
  logic             unused_sat;

  // Product arrives zero-padded; fill the upper bits with its sign for signed samples.
  assign prod_hi_mask = ~((acc_wide_t'(1) << PROD_W) - acc_wide_t'(1));
  assign prod_ext     = in_prod_i |
                        ({MaxAccW{in_sgn_i & in_prod_i[PROD_W-1]}} & prod_hi_mask);
  assign acc_ext      = in_sgn_i ? acc_wide_t'($signed(acc_q)) : acc_wide_t'(acc_q);
  assign sat          = sat_add(acc_ext, prod_ext, in_sgn_i, SATURATE, ACC_W);
  assign unused_sat   = ^sat;

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    acc_valid_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (in_v_i) begin
      acc_d       = sat[ACC_W-1:0];
      ovf_d       = ovf_q | sat[MaxAccW];
      acc_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign acc_o       = acc_q;
  assign acc_valid_o = acc_valid_q;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/mac_pipe_sat.sv
// Three-stage pipelined multiply-accumulate: S1 operand register, S2 multiply, S3 accumulate.
module mac_pipe_sat
  import mac_pkg::*;
#(
  parameter int unsigned A_W      = ADefW,
  parameter int unsigned B_W      = BDefW,
  parameter int unsigned ACC_W    = AccDefW,
  parameter bit          SATURATE = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mac_pipe_sat_if.slave mac
);

  localparam int unsigned PW = A_W + B_W;

  if (ACC_W < PW) begin : g_bad_acc_w
    $error("mac_pipe_sat: ACC_W must be at least A_W+B_W");
  end
  if (ACC_W >= MaxAccW) begin : g_wide_acc_w
    $error("mac_pipe_sat: ACC_W must be below MaxAccW");
  end

  logic           s1_v_q, s1_v_d;
  logic           s1_sgn_q, s1_sgn_d;
  logic [A_W-1:0] s1_a_q, s1_a_d;
  logic [B_W-1:0] s1_b_q, s1_b_d;
  s2_stage_t      s2_q, s2_d;

  logic signed [PW-1:0] a_s, b_s;
  logic        [PW-1:0] a_u, b_u;
  logic        [PW-1:0] prod;

  always_comb begin
    s1_v_d   = mac.en;
    s1_sgn_d = s1_sgn_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    if (mac.en) begin
      s1_sgn_d = mac.sgn;
      s1_a_d   = mac.a_in;
      s1_b_d   = mac.b_in;
    end
  end

  always_comb begin
    a_s  = PW'($signed(s1_a_q));
    b_s  = PW'($signed(s1_b_q));
    a_u  = PW'(s1_a_q);
    b_u  = PW'(s1_b_q);
    prod = s1_sgn_q ? PW'(a_s * b_s) : PW'(a_u * b_u);
  end

  // clr drops the sample moving into S2 so it never reaches the new sum.
  always_comb begin
    s2_d     = s2_q;
    s2_d.v   = s1_v_q & ~mac.clr;
    if (s1_v_q) begin
      s2_d.sgn  = s1_sgn_q;
      s2_d.prod = acc_wide_t'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_sgn_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s2_q     <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_sgn_q <= s1_sgn_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s2_q     <= s2_d;
    end
  end

  logic [ACC_W-1:0] acc;
  logic             acc_valid;
  logic             ovf;

  mac_sat_acc #(
    .ACC_W   (ACC_W),
    .PROD_W  (PW),
    .SATURATE(SATURATE)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (mac.clr),
    .in_v_i     (s2_q.v),
    .in_sgn_i   (s2_q.sgn),
    .in_prod_i  (s2_q.prod),
    .acc_o      (acc),
    .acc_valid_o(acc_valid),
    .ovf_o      (ovf)
  );

  assign mac.acc_out   = acc;
  assign mac.acc_valid = acc_valid;
  assign mac.ovf       = ovf;
  assign mac.busy      = s1_v_q | s2_q.v;

endmodule

// File: tb/tb_mac_pipe_sat.sv
// Directed bench for mac_pipe_sat: a saturating and a wrapping instance driven with the same stimulus.
module tb_mac_pipe_sat;

  logic       clk;
  logic       rst_n;
  logic       en, clr, sgn;
  logic [7:0] a, b;
  int         n_vec;
  int         n_err;

  mac_pipe_sat_if #(.A_W(8), .B_W(8), .ACC_W(24)) if_s ();
  mac_pipe_sat_if #(.A_W(8), .B_W(8), .ACC_W(24)) if_w ();

  assign if_s.en = en;  assign if_s.clr = clr;  assign if_s.sgn = sgn;
  assign if_s.a_in = a; assign if_s.b_in = b;
  assign if_w.en = en;  assign if_w.clr = clr;  assign if_w.sgn = sgn;
  assign if_w.a_in = a; assign if_w.b_in = b;

  mac_pipe_sat #(.A_W(8), .B_W(8), .ACC_W(24), .SATURATE(1'b1)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mac  (if_s)
  );

  mac_pipe_sat #(.A_W(8), .B_W(8), .ACC_W(24), .SATURATE(1'b0)) u_dut_wrap (
    .clk  (clk),
    .rst_n(rst_n),
    .mac  (if_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycle(input logic e, input logic c, input logic s,
                       input logic [7:0] av, input logic [7:0] bv);
    en = e; clr = c; sgn = s; a = av; b = bv;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    en = 1'b0; clr = 1'b0; sgn = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'd9, 8'd9);
    cycle(1'b1, 1'b0, 1'b0, 8'd9, 8'd9);
    do_reset();
    n_vec++; if (if_s.acc_out !== 24'd0) begin n_err++; $display("FAIL reset_acc: got %0d want 0", if_s.acc_out); end
    n_vec++; if (if_s.acc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_s.acc_valid); end
    n_vec++; if (if_s.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", if_s.ovf); end
    n_vec++; if (if_s.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", if_s.busy); end
  endtask

  task automatic test_latency();
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'd3, 8'd4);
    n_vec++; if (if_s.busy !== 1'b1) begin n_err++; $display("FAIL lat_busy1: got %b want 1", if_s.busy); end
    n_vec++; if (if_s.acc_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid1: got %b want 0", if_s.acc_valid); end
    idle(1);
    n_vec++; if (if_s.busy !== 1'b1) begin n_err++; $display("FAIL lat_busy2: got %b want 1", if_s.busy); end
    n_vec++; if (if_s.acc_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid2: got %b want 0", if_s.acc_valid); end
    idle(1);
    n_vec++; if (if_s.acc_out !== 24'd12) begin n_err++; $display("FAIL lat_acc: got %0d want 12", if_s.acc_out); end
    n_vec++; if (if_s.acc_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid3: got %b want 1", if_s.acc_valid); end
    n_vec++; if (if_s.busy !== 1'b0) begin n_err++; $display("FAIL lat_busy3: got %b want 0", if_s.busy); end
    idle(1);
    n_vec++; if (if_s.acc_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid4: got %b want 0", if_s.acc_valid); end
    n_vec++; if (if_s.acc_out !== 24'd12) begin n_err++; $display("FAIL lat_hold: got %0d want 12", if_s.acc_out); end
  endtask

  task automatic test_unsigned_sat();
    do_reset();
    for (int i = 0; i < 258; i++) cycle(1'b1, 1'b0, 1'b0, 8'd255, 8'd255);
    idle(2);
    n_vec++; if (if_s.acc_out !== 24'd16776450) begin n_err++; $display("FAIL usat_258_acc: got %0d want 16776450", if_s.acc_out); end
    n_vec++; if (if_s.ovf !== 1'b0) begin n_err++; $display("FAIL usat_258_ovf: got %b want 0", if_s.ovf); end
    n_vec++; if (if_w.acc_out !== 24'd16776450) begin n_err++; $display("FAIL uwrap_258_acc: got %0d want 16776450", if_w.acc_out); end
    cycle(1'b1, 1'b0, 1'b0, 8'd255, 8'd255);
    idle(2);
    n_vec++; if (if_s.acc_valid !== 1'b1) begin n_err++; $display("FAIL usat_259_valid: got %b want 1", if_s.acc_valid); end
    n_vec++; if (if_s.acc_out !== 24'd16777215) begin n_err++; $display("FAIL usat_259_acc: got %0d want 16777215", if_s.acc_out); end
    n_vec++; if (if_s.ovf !== 1'b1) begin n_err++; $display("FAIL usat_259_ovf: got %b want 1", if_s.ovf); end
    n_vec++; if (if_w.acc_out !== 24'd64259) begin n_err++; $display("FAIL uwrap_259_acc: got %0d want 64259", if_w.acc_out); end
    n_vec++; if (if_w.ovf !== 1'b1) begin n_err++; $display("FAIL uwrap_259_ovf: got %b want 1", if_w.ovf); end
  endtask

  task automatic test_signed();
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 8'h80, 8'h80);
    cycle(1'b1, 1'b0, 1'b1, 8'h80, 8'h7F);
    idle(1);
    n_vec++; if (if_s.acc_out !== 24'd16384) begin n_err++; $display("FAIL sgn_first: got %0d want 16384", if_s.acc_out); end
    idle(1);
    n_vec++; if (if_s.acc_out !== 24'd128) begin n_err++; $display("FAIL sgn_second: got %0d want 128", if_s.acc_out); end
    for (int i = 0; i < 516; i++) cycle(1'b1, 1'b0, 1'b1, 8'h80, 8'h7F);
    idle(2);
    n_vec++; if (if_s.acc_out !== 24'h800280) begin n_err++; $display("FAIL sgn_516_acc: got %h want 800280", if_s.acc_out); end
    n_vec++; if (if_s.ovf !== 1'b0) begin n_err++; $display("FAIL sgn_516_ovf: got %b want 0", if_s.ovf); end
    cycle(1'b1, 1'b0, 1'b1, 8'h80, 8'h7F);
    idle(2);
    n_vec++; if (if_s.acc_out !== 24'h800000) begin n_err++; $display("FAIL sgn_clamp_acc: got %h want 800000", if_s.acc_out); end
    n_vec++; if (if_s.ovf !== 1'b1) begin n_err++; $display("FAIL sgn_clamp_ovf: got %b want 1", if_s.ovf); end
    n_vec++; if (if_w.acc_out !== 24'h7FC300) begin n_err++; $display("FAIL sgn_wrap_acc: got %h want 7fc300", if_w.acc_out); end
    n_vec++; if (if_w.ovf !== 1'b1) begin n_err++; $display("FAIL sgn_wrap_ovf: got %b want 1", if_w.ovf); end
  endtask

  // Runs straight after test_signed, so ovf starts set.
  task automatic test_clear();
    cycle(1'b1, 1'b0, 1'b0, 8'd2, 8'd3);
    cycle(1'b1, 1'b1, 1'b0, 8'd5, 8'd5);
    n_vec++; if (if_s.acc_out !== 24'd0) begin n_err++; $display("FAIL clr_acc0: got %0d want 0", if_s.acc_out); end
    n_vec++; if (if_s.ovf !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", if_s.ovf); end
    n_vec++; if (if_w.ovf !== 1'b0) begin n_err++; $display("FAIL clr_ovf_wrap: got %b want 0", if_w.ovf); end
    idle(1);
    n_vec++; if (if_s.acc_valid !== 1'b0) begin n_err++; $display("FAIL clr_no_six_valid: got %b want 0", if_s.acc_valid); end
    n_vec++; if (if_s.acc_out !== 24'd0) begin n_err++; $display("FAIL clr_no_six_acc: got %0d want 0", if_s.acc_out); end
    idle(1);
    n_vec++; if (if_s.acc_out !== 24'd25) begin n_err++; $display("FAIL clr_acc25: got %0d want 25", if_s.acc_out); end
    n_vec++; if (if_s.acc_valid !== 1'b1) begin n_err++; $display("FAIL clr_valid25: got %b want 1", if_s.acc_valid); end
    idle(1);
    n_vec++; if (if_s.acc_out !== 24'd25) begin n_err++; $display("FAIL clr_hold25: got %0d want 25", if_s.acc_out); end
  endtask

  task automatic test_bubbles();
    logic        pat_en [7];
    logic [23:0] pat_acc [7];
    logic        pat_v [7];
    pat_en  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pat_acc = '{24'd0, 24'd0, 24'd1, 24'd1, 24'd1, 24'd2, 24'd2};
    pat_v   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    idle(1);
    for (int i = 0; i < 7; i++) begin
      cycle(pat_en[i], 1'b0, 1'b0, 8'd1, 8'd1);
      n_vec++; if (if_s.acc_out !== pat_acc[i]) begin n_err++; $display("FAIL bub_acc[%0d]: got %0d want %0d", i, if_s.acc_out, pat_acc[i]); end
      n_vec++; if (if_s.acc_valid !== pat_v[i]) begin n_err++; $display("FAIL bub_valid[%0d]: got %b want %b", i, if_s.acc_valid, pat_v[i]); end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'd200, 8'd200);
    cycle(1'b1, 1'b0, 1'b1, 8'hFF, 8'h01);
    n_vec++; if (if_s.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", if_s.busy); end
    idle(1);
    n_vec++; if (if_s.acc_out !== 24'd40000) begin n_err++; $display("FAIL b2b_unsigned: got %0d want 40000", if_s.acc_out); end
    n_vec++; if (if_s.acc_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid1: got %b want 1", if_s.acc_valid); end
    idle(1);
    n_vec++; if (if_s.acc_out !== 24'd39999) begin n_err++; $display("FAIL b2b_signed: got %0d want 39999", if_s.acc_out); end
    n_vec++; if (if_s.acc_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid2: got %b want 1", if_s.acc_valid); end
    n_vec++; if (if_s.ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", if_s.ovf); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'd7, 8'd7);
    cycle(1'b1, 1'b0, 1'b0, 8'd7, 8'd7);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (if_s.acc_out !== 24'd0) begin n_err++; $display("FAIL arst_acc: got %0d want 0", if_s.acc_out); end
    n_vec++; if (if_w.acc_out !== 24'd0) begin n_err++; $display("FAIL arst_acc_wrap: got %0d want 0", if_w.acc_out); end
    n_vec++; if (if_s.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", if_s.busy); end
    n_vec++; if (if_s.acc_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", if_s.acc_valid); end
    n_vec++; if (if_s.ovf !== 1'b0) begin n_err++; $display("FAIL arst_ovf: got %b want 0", if_s.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_vec++; if (if_s.acc_valid !== 1'b0) begin n_err++; $display("FAIL arst_post_valid[%0d]: got %b want 0", i, if_s.acc_valid); end
      n_vec++; if (if_s.acc_out !== 24'd0) begin n_err++; $display("FAIL arst_post_acc[%0d]: got %0d want 0", i, if_s.acc_out); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; sgn = 1'b0; a = '0; b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_latency();
    test_unsigned_sat();
    test_signed();
    test_clear();
    test_bubbles();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
